// File: rtl/mult_nxn_seq_pkg.sv
// Shared types and helpers for the sequential NxN multiplier.
// MULT_SIGNED_EN enables two's-complement operands via the sgn port.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINAL
  } state_e;

  localparam int CHUNK_DEF = 16;

  function automatic int step_count(int width, int chunk);
    return (width / chunk) * (width / chunk);
  endfunction

endpackage

// File: rtl/mult_nxn_seq_if.sv
// Request/result bundle of the sequential multiplier.
// MULT_SIGNED_EN adds the sgn operand-mode line.
interface mult_nxn_seq_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

`ifdef MULT_SIGNED_EN
  logic               sgn;

  modport master (
    output start, a, b, sgn,
    input  busy, done, product
  );
  modport slave (
    input  start, a, b, sgn,
    output busy, done, product
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, product
  );
  modport slave (
    input  start, a, b,
    output busy, done, product
  );
`endif

endinterface

// File: rtl/mult_nxn_fsm.sv
// Sequencer: state register and i/j chunk indices, j stepping fastest.
// Emits load, accumulate and finalize strobes for the datapath.
module mult_nxn_fsm
  import mult_pkg::*;
#(
  parameter int K  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          load,
  output logic          acc_en,
  output logic          fin,
  output logic          busy,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j
);

  state_e state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            i     <= '0;
            j     <= '0;
          end
        end
        RUN: begin
          if (j == IW'(K - 1)) begin
            j <= '0;
            if (i == IW'(K - 1)) begin
              i     <= '0;
              state <= FINAL;
            end else begin
              i <= i + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        FINAL:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign load   = (state == IDLE) && start;
  assign acc_en = (state == RUN);
  assign fin    = (state == FINAL);
  assign busy   = (state != IDLE);

endmodule

// File: rtl/mult_nxn_seq.sv
// Sequential WIDTH x WIDTH multiplier, one CHUNK x CHUNK product per cycle.
// MULT_SIGNED_EN adds sign-magnitude handling of two's-complement operands.
module mult_nxn_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = CHUNK_DEF
) (
  input logic            clk,
  input logic            reset,
  mult_nxn_seq_if.slave  bus
);

  localparam int K  = WIDTH / CHUNK;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2 * WIDTH;

  if ((WIDTH % CHUNK) != 0 || step_count(WIDTH, CHUNK) < 1) begin : g_bad_cfg
    $error("mult_nxn_seq: WIDTH must be a positive multiple of CHUNK");
  end

  logic          load, acc_en, fin, busy;
  logic [IW-1:0] i, j;

  mult_nxn_fsm #(.K(K), .IW(IW)) u_fsm (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.start),
    .load   (load),
    .acc_en (acc_en),
    .fin    (fin),
    .busy   (busy),
    .i      (i),
    .j      (j)
  );

  logic [WIDTH-1:0]   a_op, b_op, a_mag, b_mag;
  logic [PW-1:0]      acc, result, prod_q, term;
  logic [CHUNK-1:0]   ca, cb;
  logic [2*CHUNK-1:0] pp;
  logic               done_q;
  int                 ia, jb, sh;

`ifdef MULT_SIGNED_EN
  logic neg;
  logic a_neg, b_neg;

  // Magnitudes are taken as unsigned, so |min| = min maps to 2^(WIDTH-1).
  always_comb begin
    a_neg  = bus.sgn & bus.a[WIDTH-1];
    b_neg  = bus.sgn & bus.b[WIDTH-1];
    a_mag  = a_neg ? -bus.a : bus.a;
    b_mag  = b_neg ? -bus.b : bus.b;
    result = neg ? -acc : acc;
  end
`else
  always_comb begin
    a_mag  = bus.a;
    b_mag  = bus.b;
    result = acc;
  end
`endif

  always_comb begin
    ia   = int'(i) * CHUNK;
    jb   = int'(j) * CHUNK;
    sh   = ia + jb;
    ca   = a_op[ia +: CHUNK];
    cb   = b_op[jb +: CHUNK];
    pp   = {{CHUNK{1'b0}}, ca} * {{CHUNK{1'b0}}, cb};
    term = PW'(pp) << sh;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_op   <= '0;
      b_op   <= '0;
      acc    <= '0;
      prod_q <= '0;
      done_q <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else begin
      if (load) begin
        a_op <= a_mag;
        b_op <= b_mag;
        acc  <= '0;
`ifdef MULT_SIGNED_EN
        neg  <= (bus.sgn & bus.a[WIDTH-1]) ^ (bus.sgn & bus.b[WIDTH-1]);
`endif
      end else if (acc_en) begin
        acc <= acc + term;
      end
      done_q <= fin;
      if (fin) prod_q <= result;
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done_q;
  assign bus.product = prod_q;

endmodule
